khalid_fatima_mealy: RTL and testbench



---
 rtl/khalid_fatima_mealy_pkg.sv | 16 +
 rtl/mealy_1011_fsm.sv | 46 ++++
 rtl/khalid_fatima_mealy.sv | 84 ++++++++
 tb/tb_khalid_fatima_mealy.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/khalid_fatima_mealy_pkg.sv
// rtl/khalid_fatima_mealy_pkg.sv - shared types and pin indices for the 1011 detector
package khalid_fatima_mealy_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  localparam int DIN_BIT   = 0;
  localparam int VALID_BIT = 1;
  localparam int CLR_BIT   = 2;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mealy_1011_fsm.sv
// rtl/mealy_1011_fsm.sv - overlapping Mealy detector for serial pattern 1011
module mealy_1011_fsm
  import khalid_fatima_mealy_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   sample_i,
  input  logic   din_i,
  input  logic   clear_i,
  output state_e state_o,
  output logic   detect_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear wins over a simultaneous sample and suppresses its detect.
  always_comb begin
    state_d  = state_q;
    detect_o = 1'b0;
    if (clear_i) begin
      state_d = S0;
    end else if (sample_i) begin
      unique case (state_q)
        S0: state_d = din_i ? S1 : S0;
        S1: state_d = din_i ? S1 : S2;
        S2: state_d = din_i ? S3 : S0;
        S3: begin
          state_d  = din_i ? S1 : S2;
          detect_o = din_i;
        end
        default: state_d = S0;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/khalid_fatima_mealy.sv
// rtl/khalid_fatima_mealy.sv - TT wrapper for the 1011 detector; DETECT_COUNT_EN adds the uio counter
module khalid_fatima_mealy
  import khalid_fatima_mealy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic   sample;
  logic   clear;
  logic   detect;
  state_e state;
  logic   detect_q_q, detect_q_d;

  assign sample = ena & ui_in[VALID_BIT];
  assign clear  = ena & ui_in[CLR_BIT];

  mealy_1011_fsm u_fsm (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sample_i (sample),
    .din_i    (ui_in[DIN_BIT]),
    .clear_i  (clear),
    .state_o  (state),
    .detect_o (detect)
  );

  always_comb begin
    detect_q_d = detect_q_q;
    if (clear) begin
      detect_q_d = 1'b0;
    end else if (ena) begin
      detect_q_d = detect;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect_q_q <= 1'b0;
    end else begin
      detect_q_q <= detect_q_d;
    end
  end

`ifdef DETECT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free-running modulo-256 count of detects.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (detect) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign uio_out = cnt_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  assign uo_out = {4'b0000, detect_q_q, state, detect};

  logic unused_pins;
  assign unused_pins = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_khalid_fatima_mealy.sv
// tb/tb_khalid_fatima_mealy.sv - directed self-checking bench for khalid_fatima_mealy
module tb_khalid_fatima_mealy;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         n_checks;
  int         n_errors;
  logic       exp_dq;
  logic [7:0] exp_cnt;

  khalid_fatima_mealy dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_uio();
`ifdef DETECT_COUNT_EN
    return exp_cnt;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] exp_oe();
`ifdef DETECT_COUNT_EN
    return 8'hFF;
`else
    return 8'h00;
`endif
  endfunction

  task automatic step(input logic en, input logic [2:0] ctl, input logic exp_det);
    @(negedge clk);
    ena    = en;
    ui_in  = {5'($urandom), ctl};
    uio_in = 8'($urandom);
    #1;
    check("detect", 32'(uo_out[0]), 32'(exp_det));
    if (en && ctl[2]) begin
      exp_dq  = 1'b0;
      exp_cnt = 8'h00;
    end else if (en) begin
      exp_dq = exp_det;
      if (exp_det) exp_cnt = exp_cnt + 8'h01;
    end
    @(posedge clk);
    #1;
    check("detect_q", 32'(uo_out[3]), 32'(exp_dq));
    check("uo_hi_zero", 32'(uo_out[7:4]), 32'h0);
    check("count", 32'(uio_out), 32'(exp_uio()));
  endtask

  task automatic send(input logic [31:0] bits, input int n, input logic [31:0] dets);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, {1'b0, 1'b1, bits[i]}, dets[i]);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    check(tag, 32'(uo_out[2:1]), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_dq   = 1'b0;
    exp_cnt  = 8'h00;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h00);
    check("rst_oe", 32'(uio_oe), 32'(exp_oe()));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic match 1011
    send(32'b1011, 4, 32'b0001);
    check_state("basic_state", 2'b01);
    step(1'b1, 3'b000, 1'b0);

    // Overlap 1011011 after clear
    step(1'b1, 3'b100, 1'b0);
    check_state("clr_state", 2'b00);
    send(32'b1011011, 7, 32'b0001001);

    // Non-match prefix 1001011
    step(1'b1, 3'b100, 1'b0);
    send(32'b1001011, 7, 32'b0000001);

    // Invalid cycles inside a pattern hold state (from S1)
    step(1'b1, 3'b011, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    check_state("hold_s2", 2'b10);
    step(1'b1, 3'b011, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    check_state("hold_s3", 2'b11);
    step(1'b1, 3'b011, 1'b1);

    // Third detect, then ena=0 and clear behaviour
    send(32'b011, 3, 32'b001);
    send(32'b01, 2, 32'b00);
    check_state("pre_ena_s3", 2'b11);
    step(1'b0, 3'b011, 1'b0);
    step(1'b0, 3'b111, 1'b0);
    check_state("ena0_hold", 2'b11);
    step(1'b1, 3'b111, 1'b0);
    check_state("clear_s0", 2'b00);
    check("clear_cnt", 32'(uio_out), 32'h00);

    // 256 back-to-back overlapping matches wrap the counter
    send(32'b1011, 4, 32'b0001);
    for (int k = 0; k < 255; k++) begin
      send(32'b011, 3, 32'b001);
    end
    check("wrap_cnt", 32'(uio_out), 32'h00);

    // Async reset after 101 discards the partial match
    step(1'b1, 3'b100, 1'b0);
    send(32'b101, 3, 32'b000);
    check_state("pre_rst_s3", 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_uo", 32'(uo_out), 32'h00);
    check("async_rst_uio", 32'(uio_out), 32'h00);
    #2;
    rst_n   = 1'b1;
    exp_dq  = 1'b0;
    exp_cnt = 8'h00;
    send(32'b1, 1, 32'b0);
    check_state("post_rst_s1", 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
